uart_rx: RTL

- UART receiver; the counterpart of the existing uart_tx.
- Samples serial line `rx` using the 16x oversampling tick from br_generator (same `i_ticks` contract as uart_tx).
- Deserialises LSB-first 8N1 frames and presents each byte with a one-cycle done pulse.
- Flags a framing error when the stop bit is low.
- Sits beside uart_tx under a top-level wrapper; `rx` comes from the board pin.

---
 rtl/uart_rx.sv | 116 +++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, LSB-first 8N1 deserialiser with a 2-flop input
// synchroniser, a one-clock done pulse per good byte and a framing-error pulse.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICKS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_ticks,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] o_data_byte,
    output logic                  o_rx_done,
    output logic                  o_frame_err,
    output logic                  o_busy
);

    localparam int              NW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [NW-1:0]   N_LAST = NW'(DATA_WIDTH - 1);
    localparam logic [4:0]      S_LAST = 5'(SB_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                r_state;
    logic [1:0]            r_sync;
    logic [4:0]            r_s;
    logic [NW-1:0]         r_n;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_done;
    logic                  r_ferr;
    logic                  w_rx_s;

    assign w_rx_s      = r_sync[1];
    assign o_data_byte = r_data;
    assign o_rx_done   = r_done;
    assign o_frame_err = r_ferr;
    assign o_busy      = (r_state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync  <= '1;
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], rx};
            r_done <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Start-bit detection is tick-independent so back-to-back frames lose nothing.
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_s     <= '0;
                    end
                end
                START: begin
                    if (i_ticks) begin
                        if (r_s == 5'd7) begin
                            r_s <= '0;
                            if (!w_rx_s) begin
                                r_state <= DATA;
                                r_n     <= '0;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (i_ticks) begin
                        if (r_s == 5'd15) begin
                            r_s <= '0;
                            r_b <= {w_rx_s, r_b[DATA_WIDTH-1:1]};
                            if (r_n == N_LAST) begin
                                r_state <= STOP;
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (i_ticks) begin
                        if (r_s == S_LAST) begin
                            r_state <= IDLE;
                            if (w_rx_s) begin
                                r_data <= r_b;
                                r_done <= 1'b1;
                            end else begin
                                r_ferr <= 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
